// File: rtl/instr_fetch_assembler.sv
// Instruction fetch: reads four bytes per instruction from a byte-wide memory and assembles them big-endian.
// Latency: first word 4 cycles after reset release; 5 cycles/word (4 cycles/word with PREFETCH_EN).
// Backpressure: instr_word/instr_pc held stable while instr_valid=1 and instr_ready=0; fetching stalls (or parks at the last byte with PREFETCH_EN).
//
// Optional feature macro: PREFETCH_EN
//   undefined : after a word completes the fetcher idles in WAIT until decode accepts it.
//   defined   : the fetcher keeps assembling the next word while the current one is
//               presented; the final byte is only committed once the output slot frees up.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mem_enable, mem_read_write,   instruction memory control (always a read)
//   mem_address, mem_data_in      byte address out, combinational byte in
//   redirect_valid, redirect_pc   one-cycle branch/jump redirect; always wins
//   instr_valid, instr_ready      valid/ready handshake toward decode
//   instr_word, instr_pc          assembled instruction and its byte address
//   align_err                     one-cycle pulse on a misaligned redirect target
module instr_fetch_assembler #(
  parameter int ADDR_WIDTH = 9,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  mem_enable,
  output logic                  mem_read_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [7:0]            mem_data_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_word,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  align_err
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(4);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  valid_q, valid_d;
  logic                  align_q, align_d;

  // Byte address currently being read; wraps naturally at 2^ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           word_new;
  logic [23:0]           asm_shift;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign cur_addr  = fetch_pc_q + ADDR_WIDTH'(cnt_q);
  assign word_new  = {asm_q, mem_data_in};
  assign asm_shift = {asm_q[15:0], mem_data_in};
  assign pc_next   = fetch_pc_q + PC_INC;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    word_d     = word_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    align_d    = 1'b0;
    // Remember the last fetched address so the bus stays quiet (no toggling) in WAIT.
    last_addr_d = (state_q == S_FETCH) ? cur_addr : last_addr_q;

    if (redirect_valid) begin
      // Redirect overrides completion, handshake and prefetch in the same cycle;
      // any partial assembly and any unconsumed instruction are dropped.
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      cnt_d      = 2'd0;
      asm_d      = '0;
      valid_d    = 1'b0;
      state_d    = S_FETCH;
      align_d    = |redirect_pc[1:0];
    end else begin
`ifdef PREFETCH_EN
      if (valid_q && instr_ready) begin
        valid_d = 1'b0;
      end
      if (cnt_q != 2'd3) begin
        asm_d = asm_shift;
        cnt_d = cnt_q + 2'd1;
      end else if (!valid_q || instr_ready) begin
        // Output slot is free (or freeing this edge): commit the word.
        word_d     = word_new;
        pc_d       = fetch_pc_q;
        valid_d    = 1'b1;
        fetch_pc_d = pc_next;
        cnt_d      = 2'd0;
        asm_d      = '0;
      end
      // else: park on the last byte, same address, retry next cycle.
`else
      case (state_q)
        S_FETCH: begin
          if (cnt_q != 2'd3) begin
            asm_d = asm_shift;
            cnt_d = cnt_q + 2'd1;
          end else begin
            word_d     = word_new;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = pc_next;
            cnt_d      = 2'd0;
            asm_d      = '0;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RST_PC;
      cnt_q       <= 2'd0;
      asm_q       <= '0;
      word_q      <= '0;
      pc_q        <= RST_PC;
      last_addr_q <= RST_PC;
      valid_q     <= 1'b0;
      align_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      word_q      <= word_d;
      pc_q        <= pc_d;
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      align_q     <= align_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The state register already sits in FETCH during reset, so gate the enable
  // with reset_n to keep the memory idle until fetching actually starts.
  assign mem_enable     = reset_n && (state_q == S_FETCH);
  assign mem_read_write = 1'b1;
  assign mem_address    = (state_q == S_FETCH) ? cur_addr : last_addr_q;
  assign instr_valid    = valid_q;
  assign instr_word     = word_q;
  assign instr_pc       = pc_q;
  assign align_err      = align_q;

endmodule
